// File: rtl/satalnk_addcont.sv
// SATA link TX primitive encoder: folds repeated primitives into P_CONT plus
// scrambled junk dwords and inserts a P_ALIGN pair every 2^LGALIGN output dwords.
module satalnk_addcont #(
   parameter logic [31:0] P_ALIGN = 32'hbc4a_4a7b,
   parameter logic [31:0] P_CONT  = 32'h7caa_9999,
   parameter logic [31:0] P_SYNC  = 32'hb5b5_957c,
   parameter int          LGALIGN = 8
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_cfg_continue_en,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        s_primitive,
   input  logic [31:0] s_data,
   output logic        o_primitive,
   output logic [31:0] o_data
);

   logic [LGALIGN-1:0] cnt_q, cnt_d;
   logic [1:0]         run_q, run_d;
   logic [31:0]        last_q, last_d;
   logic [31:0]        lfsr_q, lfsr_d;
   logic               o_primitive_q, o_primitive_d;
   logic [31:0]        o_data_q, o_data_d;
   logic               sel_prim;
   logic [31:0]        sel_data;

   // Counts 0 and 1 are the ALIGN slots; every other count takes a word.
   assign s_ready     = |cnt_q[LGALIGN-1:1];
   assign o_primitive = o_primitive_q;
   assign o_data      = o_data_q;
   assign sel_prim    = s_valid ? s_primitive : 1'b1;
   assign sel_data    = s_valid ? s_data : P_SYNC;

   always_comb begin
      cnt_d         = cnt_q + 1'b1;
      run_d         = run_q;
      last_d        = last_q;
      lfsr_d        = lfsr_q;
      o_primitive_d = 1'b1;
      o_data_d      = P_ALIGN;
      if (s_ready) begin
         o_primitive_d = sel_prim;
         o_data_d      = sel_data;
         if (!sel_prim) begin
            run_d = 2'd0;
         end else if (sel_data != last_q || run_q == 2'd0) begin
            last_d = sel_data;
            run_d  = 2'd1;
         end else begin
            case (run_q)
               2'd1:    run_d = 2'd2;
               2'd2: begin
                  if (i_cfg_continue_en) begin
                     o_data_d = P_CONT;
                     run_d    = 2'd3;
                  end
               end
               default: begin
                  // Junk dwords go out as data so the far end never sees them as K-chars.
                  if (i_cfg_continue_en) begin
                     o_primitive_d = 1'b0;
                     o_data_d      = lfsr_q;
                     lfsr_d        = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
                  end else begin
                     run_d = 2'd2;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         cnt_q         <= '0;
         run_q         <= 2'd0;
         last_q        <= P_SYNC;
         lfsr_q        <= 32'hffff_ffff;
         o_primitive_q <= 1'b1;
         o_data_q      <= P_SYNC;
      end else begin
         cnt_q         <= cnt_d;
         run_q         <= run_d;
         last_q        <= last_d;
         lfsr_q        <= lfsr_d;
         o_primitive_q <= o_primitive_d;
         o_data_q      <= o_data_d;
      end
   end

endmodule

// File: tb/tb_satalnk_addcont.sv
// Randomized and directed checks of satalnk_addcont against a cycle-level
// reference model built from the primitive-suppression rules.
module tb_satalnk_addcont;

   localparam logic [31:0] P_ALIGN = 32'hbc4a_4a7b;
   localparam logic [31:0] P_CONT  = 32'h7caa_9999;
   localparam logic [31:0] P_SYNC  = 32'hb5b5_957c;
   localparam logic [31:0] X_RDY   = 32'h5757_b57c;
   localparam logic [31:0] R_RDY   = 32'h4a4a_957c;
   localparam logic [31:0] HOLD    = 32'hd5d5_aa7c;
   localparam int          PERIOD  = 256;

   logic        clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        cont_en = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        s_primitive = 1'b0;
   logic [31:0] s_data = 32'h0;
   logic        o_primitive;
   logic [31:0] o_data;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_slot;
   int          m_run;
   logic [31:0] m_last;
   logic [31:0] m_lfsr;

   logic        ob_rdy, ob_prim, ex_rdy, ex_prim;
   logic [31:0] ob_data, ex_data;

   satalnk_addcont dut (
      .i_clk(clk), .i_reset_n(i_reset_n), .i_cfg_continue_en(cont_en),
      .s_valid(s_valid), .s_ready(s_ready), .s_primitive(s_primitive), .s_data(s_data),
      .o_primitive(o_primitive), .o_data(o_data)
   );

   always #5 clk = ~clk;

   // Scrambler polynomial x^32+x^22+x^2+x+1, written as explicit tap terms.
   function automatic logic [31:0] scramble_next(input logic [31:0] s);
      logic fb;
      fb = s[32-1] ^ s[22-1] ^ s[2-1] ^ s[1-1];
      return (s << 1) | {31'd0, fb};
   endfunction

   task automatic do_reset();
      i_reset_n = 1'b0;
      @(posedge clk); #1;
      i_reset_n = 1'b1;
      m_slot = 0; m_run = 0; m_last = P_SYNC; m_lfsr = 32'hffff_ffff;
      ex_prim = 1'b1; ex_data = P_SYNC;
      ob_prim = o_primitive; ob_data = o_data;
   endtask

   // Drives one cycle and leaves observed/expected values for the caller to compare.
   task automatic step(input logic v, input logic p, input logic [31:0] d);
      logic        wp;
      logic [31:0] wd;
      s_valid = v; s_primitive = p; s_data = d;
      #1;
      ob_rdy = s_ready;
      ex_rdy = (m_slot >= 2);
      @(posedge clk); #1;
      ob_prim = o_primitive; ob_data = o_data;
      if (!ex_rdy) begin
         ex_prim = 1'b1; ex_data = P_ALIGN;
      end else begin
         wp = v ? p : 1'b1;
         wd = v ? d : P_SYNC;
         ex_prim = wp; ex_data = wd;
         if (!wp) m_run = 0;
         else if (wd != m_last || m_run == 0) begin m_last = wd; m_run = 1; end
         else if (m_run == 1) m_run = 2;
         else if (!cont_en) m_run = 2;
         else if (m_run == 2) begin ex_data = P_CONT; m_run = 3; end
         else begin ex_prim = 1'b0; ex_data = m_lfsr; m_lfsr = scramble_next(m_lfsr); end
      end
      m_slot = (m_slot + 1) % PERIOD;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ob_prim, ob_data} !== {1'b1, P_SYNC}) begin
         errors++; $display("FAIL reset_out: got %b/%h exp 1/%h", ob_prim, ob_data, P_SYNC);
      end
   endtask

   task automatic test_sync_idle();
      int nsync = 0;
      cont_en = 1'b0;
      do_reset();
      for (int i = 0; i < PERIOD + 2; i++) begin
         step(1'b1, 1'b1, P_SYNC);
         checks++;
         if ({ob_rdy, ob_prim, ob_data} !== {ex_rdy, ex_prim, ex_data}) begin
            errors++; $display("FAIL sync_idle[%0d]: got %b/%b/%h exp %b/%b/%h", i, ob_rdy, ob_prim, ob_data, ex_rdy, ex_prim, ex_data);
         end
         if (ob_prim && ob_data == P_SYNC) nsync++;
      end
      checks++;
      if (nsync != PERIOD - 2) begin errors++; $display("FAIL sync_count: got %0d exp %0d", nsync, PERIOD - 2); end
   endtask

   task automatic test_cont_run();
      logic [32:0] outs[$];
      int guard = 0;
      cont_en = 1'b1;
      do_reset();
      while (outs.size() < 10 && guard < 40) begin
         step(1'b1, 1'b1, X_RDY);
         guard++;
         checks++;
         if ({ob_rdy, ob_prim, ob_data} !== {ex_rdy, ex_prim, ex_data}) begin
            errors++; $display("FAIL cont_run: got %b/%b/%h exp %b/%b/%h", ob_rdy, ob_prim, ob_data, ex_rdy, ex_prim, ex_data);
         end
         if (ob_rdy) outs.push_back({ob_prim, ob_data});
      end
      checks++;
      if (outs.size() != 10) begin errors++; $display("FAIL cont_run_timeout: got %0d words exp 10", outs.size()); end
      else begin
         checks++;
         if (outs[0] !== {1'b1, X_RDY} || outs[1] !== {1'b1, X_RDY} || outs[2] !== {1'b1, P_CONT}) begin
            errors++; $display("FAIL cont_head: got %h %h %h exp X_RDY X_RDY CONT", outs[0], outs[1], outs[2]);
         end
         checks++;
         if (outs[3] !== {1'b0, 32'hffff_ffff} || outs[4] !== {1'b0, 32'hffff_fffe}) begin
            errors++; $display("FAIL junk_seed: got %h %h exp 0ffffffff 0fffffffe", outs[3], outs[4]);
         end
         for (int i = 5; i < 10; i++) begin
            checks++;
            if (outs[i][32] !== 1'b0) begin errors++; $display("FAIL junk_kind[%0d]: got prim=%b exp 0", i, outs[i][32]); end
         end
      end
   endtask

   task automatic test_data_break();
      logic [32:0] words[8];
      logic [32:0] outs[$];
      int guard = 0;
      cont_en = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) words[i] = {1'b1, X_RDY};
      words[5] = {1'b0, 32'h1234_5678};
      words[6] = {1'b0, 32'h9abc_def0};
      words[7] = {1'b1, X_RDY};
      while (outs.size() < 8 && guard < 40) begin
         step(1'b1, words[outs.size()][32], words[outs.size()][31:0]);
         guard++;
         checks++;
         if ({ob_rdy, ob_prim, ob_data} !== {ex_rdy, ex_prim, ex_data}) begin
            errors++; $display("FAIL data_break: got %b/%b/%h exp %b/%b/%h", ob_rdy, ob_prim, ob_data, ex_rdy, ex_prim, ex_data);
         end
         if (ob_rdy) outs.push_back({ob_prim, ob_data});
      end
      checks++;
      if (outs.size() != 8 || outs[5] !== words[5] || outs[6] !== words[6] || outs[7] !== words[7] || outs[2] !== {1'b1, P_CONT}) begin
         errors++; $display("FAIL data_verbatim: got %0d words, tail %h exp %h", outs.size(), outs[outs.size()-1], words[7]);
      end
   endtask

   task automatic test_align_wrap();
      int nconts = 0;
      int naligns = 0;
      cont_en = 1'b1;
      for (int i = 0; i < PERIOD + 40; i++) begin
         step(1'b1, 1'b1, X_RDY);
         checks++;
         if ({ob_rdy, ob_prim, ob_data} !== {ex_rdy, ex_prim, ex_data}) begin
            errors++; $display("FAIL align_wrap[%0d]: got %b/%b/%h exp %b/%b/%h", i, ob_rdy, ob_prim, ob_data, ex_rdy, ex_prim, ex_data);
         end
         if (ob_prim && ob_data == P_CONT) nconts++;
         if (ob_prim && ob_data == P_ALIGN) naligns++;
      end
      checks++;
      if (nconts != 1 || naligns != 2) begin
         errors++; $display("FAIL align_wrap_counts: got cont=%0d align=%0d exp cont=1 align=2", nconts, naligns);
      end
   endtask

   task automatic test_reset_mid_junk();
      logic [32:0] outs[4];
      cont_en = 1'b1;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, X_RDY);
      do_reset();
      checks++;
      if ({ob_prim, ob_data} !== {1'b1, P_SYNC}) begin
         errors++; $display("FAIL reset_mid_junk: got %b/%h exp 1/%h", ob_prim, ob_data, P_SYNC);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, X_RDY);
         outs[i] = {ob_prim, ob_data};
         checks++;
         if ({ob_rdy, ob_prim, ob_data} !== {ex_rdy, ex_prim, ex_data}) begin
            errors++; $display("FAIL post_reset[%0d]: got %b/%b/%h exp %b/%b/%h", i, ob_rdy, ob_prim, ob_data, ex_rdy, ex_prim, ex_data);
         end
      end
      checks++;
      if (outs[0] !== {1'b1, P_ALIGN} || outs[1] !== {1'b1, P_ALIGN} || outs[2] !== {1'b1, X_RDY} || outs[3] !== {1'b1, X_RDY}) begin
         errors++; $display("FAIL post_reset_seq: got %h %h %h %h", outs[0], outs[1], outs[2], outs[3]);
      end
   endtask

   task automatic test_idle_sync();
      logic [32:0] outs[$];
      int guard = 0;
      cont_en = 1'b1;
      while (outs.size() < 5 && guard < 20) begin
         step(1'b0, 1'b0, 32'hdead_beef);
         guard++;
         checks++;
         if ({ob_rdy, ob_prim, ob_data} !== {ex_rdy, ex_prim, ex_data}) begin
            errors++; $display("FAIL idle: got %b/%b/%h exp %b/%b/%h", ob_rdy, ob_prim, ob_data, ex_rdy, ex_prim, ex_data);
         end
         if (ob_rdy) outs.push_back({ob_prim, ob_data});
      end
      checks++;
      if (outs.size() != 5 || outs[0] !== {1'b1, P_SYNC} || outs[1] !== {1'b1, P_SYNC} || outs[2] !== {1'b1, P_CONT}
          || outs[3][32] !== 1'b0 || outs[4][32] !== 1'b0) begin
         errors++; $display("FAIL idle_seq: got %0d words, third %h exp SYNC SYNC CONT junk junk", outs.size(), outs[2]);
      end
   endtask

   task automatic test_random();
      logic [31:0] prims[4];
      logic        v, p, hold;
      logic [31:0] d;
      prims[0] = X_RDY; prims[1] = R_RDY; prims[2] = HOLD; prims[3] = P_SYNC;
      v = 1'b0; p = 1'b0; d = 32'h0; hold = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (!hold) begin
            v = ($urandom_range(0, 7) != 0);
            p = ($urandom_range(0, 4) != 0);
            d = p ? (($urandom_range(0, 2) != 0) ? prims[0] : prims[$urandom_range(0, 3)]) : $urandom;
         end
         if ($urandom_range(0, 40) == 0) cont_en = ~cont_en;
         step(v, p, d);
         hold = v && !ob_rdy;
         checks++;
         if ({ob_rdy, ob_prim, ob_data} !== {ex_rdy, ex_prim, ex_data}) begin
            errors++; $display("FAIL random[%0d]: got %b/%b/%h exp %b/%b/%h", i, ob_rdy, ob_prim, ob_data, ex_rdy, ex_prim, ex_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sync_idle();
      test_cont_run();
      test_data_break();
      test_align_wrap();
      test_reset_mid_junk();
      test_idle_sync();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
